// File: rtl/tap_delay_line_if.sv
// Sample-in / tap-bus-out bundle for tap_delay_line; fold and fold_valid exist only with TAPLINE_FOLD_EN.
// The upstream source drives the master side; the delay line implements the slave side.
interface tap_delay_line_if #(
   parameter int DATA_WIDTH = 14,
   parameter int DEPTH      = 49
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0]        din;
   logic                         din_valid;
   logic                         clr;
   logic [DEPTH*DATA_WIDTH-1:0]  taps;
   logic [CNT_W-1:0]             fill_cnt;
   logic                         full;
   logic                         taps_valid;
`ifdef TAPLINE_FOLD_EN
   logic [((DEPTH+1)/2)*(DATA_WIDTH+1)-1:0] fold;
   logic                                    fold_valid;

   modport master (output din, din_valid, clr,
                   input  taps, fill_cnt, full, taps_valid, fold, fold_valid);
   modport slave  (input  din, din_valid, clr,
                   output taps, fill_cnt, full, taps_valid, fold, fold_valid);
`else
   modport master (output din, din_valid, clr,
                   input  taps, fill_cnt, full, taps_valid);
   modport slave  (input  din, din_valid, clr,
                   output taps, fill_cnt, full, taps_valid);
`endif
endinterface

// File: rtl/tap_delay_line.sv
// Valid-gated DEPTH-tap delay line with fill tracking; din->tap0 1 cycle, optional folded pre-add (TAPLINE_FOLD_EN) +1 cycle.
// No backpressure: every din_valid sample is accepted unless clr or reset drops it.
module tap_delay_line #(
   parameter int DATA_WIDTH = 14,
   parameter int DEPTH      = 49
) (
   input logic              clk,
   input logic              rst_n,
   tap_delay_line_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] tap_q;
   logic [CNT_W-1:0]                 fill_q;
   logic                             tvld_q;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clr) begin
         tap_q  <= '0;
         fill_q <= '0;
         tvld_q <= 1'b0;
      end else begin
         tvld_q <= bus.din_valid && (fill_q >= CNT_W'(DEPTH - 1));
         if (bus.din_valid) begin
            tap_q  <= {tap_q[DEPTH-2:0], bus.din};
            fill_q <= (fill_q == CNT_W'(DEPTH)) ? fill_q : fill_q + CNT_W'(1);
         end
      end
   end

   assign bus.taps       = tap_q;
   assign bus.fill_cnt   = fill_q;
   assign bus.full       = (fill_q == CNT_W'(DEPTH));
   assign bus.taps_valid = tvld_q;

`ifdef TAPLINE_FOLD_EN
   localparam int FN = (DEPTH + 1) / 2;

   logic [FN-1:0][DATA_WIDTH:0] fold_sum;
   logic [FN-1:0][DATA_WIDTH:0] fold_q;
   logic                        fvld_q;

   // Mirror taps pair up around the centre; an odd middle tap passes through alone.
   for (genvar j = 0; j < FN; j++) begin : g_fold
      if (j < DEPTH / 2) begin : g_pair
         assign fold_sum[j] = {tap_q[j][DATA_WIDTH-1], tap_q[j]}
                            + {tap_q[DEPTH-1-j][DATA_WIDTH-1], tap_q[DEPTH-1-j]};
      end else begin : g_mid
         assign fold_sum[j] = {tap_q[j][DATA_WIDTH-1], tap_q[j]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clr) begin
         fold_q <= '0;
         fvld_q <= 1'b0;
      end else begin
         fold_q <= fold_sum;
         fvld_q <= tvld_q;
      end
   end

   assign bus.fold       = fold_q;
   assign bus.fold_valid = fvld_q;
`endif
endmodule

// File: doc/tap_delay_line.md
# tap_delay_line

Parametrised, valid-gated tapped delay line for the DETDES datapath, generalising the fixed 49-tap shift register. Holds the last DEPTH accepted samples on a flat, packed tap bus for the downstream correlator/FIR multipliers. Tracks fill level and flags when the window is fully populated. Supports synchronous flush and an optional symmetric pre-add (folded) output stage for linear-phase filters.

## Interface
- DATA_WIDTH, 14, sample width (two's complement)
- DEPTH, 49, number of taps; legal range 2..256
- CNT_W, $clog2(DEPTH+1), fill counter width (derived, not overridden)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- din  in  DATA_WIDTH  input sample
- din_valid  in  1  shift enable; a sample is accepted on every edge where din_valid=1
- clr  in  1  synchronous flush of taps and fill count
- taps  out  DEPTH*DATA_WIDTH  tap k (0 = newest) at bits [k*DATA_WIDTH +: DATA_WIDTH]
- fill_cnt  out  CNT_W  samples held, saturates at DEPTH
- full  out  1  fill_cnt == DEPTH
- taps_valid  out  1  one-cycle pulse: taps changed on this edge and window is full
- fold  out  ((DEPTH+1)/2)*(DATA_WIDTH+1)  folded sums (only with TAPLINE_FOLD_EN)
- fold_valid  out  1  fold qualifier (only with TAPLINE_FOLD_EN)

## Operation
- Reset (rst_n=0 at edge): every tap 0, fill_cnt 0, full 0, taps_valid 0, fold 0, fold_valid 0. Overrides clr and din_valid.
- Shift (din_valid=1, clr=0): tap0 <= din; tap k <= tap k-1 for k=1..DEPTH-1; tap DEPTH-1 contents discarded. fill_cnt <= min(fill_cnt+1, DEPTH).
- Hold (din_valid=0, clr=0): all taps and fill_cnt unchanged; taps_valid 0.
- Flush (clr=1): taps 0, fill_cnt 0, taps_valid 0; concurrent din_valid sample is dropped (clr wins).
- taps_valid <= din_valid & ~clr & (fill_cnt+1 >= DEPTH) — i.e. asserted on the shift that completes the window and every shift thereafter.
- full is combinational compare of registered fill_cnt; never glitches between edges.
- Counter saturation: fill_cnt at DEPTH stays DEPTH on further shifts; no wrap.
- Reset or clr mid-stream: window restarts; DEPTH new samples required before next taps_valid.

## Timing
- din accepted at edge N appears on tap0 after edge N; on tap k after k further accepted samples.
- Latency din -> tap0: 1 cycle. taps_valid aligned with the taps it qualifies (same cycle).
- Fill: first taps_valid after the DEPTH-th accepted sample post-reset/clr; gaps in din_valid stretch fill without loss.
- Throughput: one sample per clock, back-to-back din_valid supported indefinitely.
- Fold stage (when enabled): +1 cycle; fold/fold_valid registered from taps/taps_valid.

## Configuration
- Macro TAPLINE_FOLD_EN.
- Defined: fold and fold_valid ports exist. fold[j] = sign-extended tap j + sign-extended tap DEPTH-1-j for j < DEPTH/2, width DATA_WIDTH+1, no overflow possible. If DEPTH odd, middle entry j=(DEPTH-1)/2 = sign-extended tap j alone (not doubled). fold_valid = taps_valid delayed 1 cycle; clr and reset zero fold and fold_valid on the same edge as taps.
- Undefined: fold ports absent, no adder logic; taps path identical in function and timing.

## Test plan
- Reset/fill: DEPTH=49, release rst_n, drive din=1..49 with din_valid=1 back-to-back -> taps_valid first high in the cycle after din=49 accepted, tap0=49, tap48=1, fill_cnt=49, full=1.
- Gapped input: din_valid toggling 1,0,1,0 with din=10,20,30 -> taps change only on valid edges, fill_cnt=3, tap0=30, tap2=10, taps_valid 0.
- Saturation/stream: after full, 10 more samples -> fill_cnt stays 49, taps_valid high each accepted cycle, tap48 = 11th sample of the stream.
- Flush collision: full window, clr=1 with din_valid=1, din=0x1FFF -> all taps 0, fill_cnt 0, full 0, taps_valid 0; sample dropped.
- Reset mid-stream: rst_n=0 for 1 cycle at fill_cnt=30 with din_valid=1 -> all outputs 0 next cycle; 49 further samples needed for taps_valid.
- Fold (TAPLINE_FOLD_EN, DEPTH=5, DATA_WIDTH=14): taps newest->oldest = -8192, 3, 7, 5, -8192 -> one cycle later fold[0]=-16384, fold[1]=8, fold[2]=7, fold_valid=1.
